jtframe_sdram_arb: RTL and testbench
====================================

# jtframe_sdram_arb

Request arbiter placed between game-side memory clients and the single SDRAM controller port of the board wrapper (sdram_req/sdram_ack/data_rdy). It shares that port between NSLOT read slots and one write-back slot. Writes take fixed priority and reads are served round-robin. The block holds off all new grants while ROM download is active.

## Interface
Parameters:
- NSLOT, 4, number of read slots (2..8)
- AW, 22, SDRAM word address width

Ports:
- clk_rom  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  reset
- downloading  in  1  ROM download active; blocks new grants
- slot_req  in  NSLOT  per-slot read request (level)
- slot_addr  in  NSLOT*AW  per-slot address, slot i at [i*AW+:AW]
- slot_bank  in  NSLOT*2  per-slot bank
- slot_ok  out  NSLOT  one-cycle pulse: slot_dout valid for that slot
- slot_dout  out  32  read data, shared by all slots
- wr_req  in  1  write-back request (level)
- wr_addr  in  AW  write address
- wr_bank  in  2  write bank
- wr_data  in  16  write data
- wr_mask  in  2  byte mask (1 = byte not written)
- wr_ok  out  1  one-cycle pulse: write completed
- sdram_req  out  1  request to controller
- sdram_ack  in  1  controller accepted the request (pulse)
- sdram_addr  out  AW  address
- sdram_bank  out  2  bank
- sdram_rnw  out  1  1 = read
- sdram_wrmask  out  2  write mask
- data_write  out  16  write data
- data_read  in  32  read data
- data_rdy  in  1  transaction complete (pulse)

## Operation
- FSM states: IDLE, WAIT_ACK, WAIT_RDY.
- IDLE: if downloading=1, stay. Otherwise, if wr_req=1, grant the write. Otherwise, if any slot_req is set, grant the first requesting slot at or after pointer rr, wrapping modulo NSLOT.
- On grant:
  - Latch address, bank, rnw, mask and data into the sdram_* registers.
  - Set sdram_req=1 and record the owner.
  - Go to WAIT_ACK.
- WAIT_ACK: hold sdram_req and all sdram_* outputs stable. When sdram_ack=1, clear sdram_req and go to WAIT_RDY.
- WAIT_RDY: when data_rdy=1:
  - For a read, latch data_read into slot_dout, pulse slot_ok[owner], and set rr = owner+1, wrapping to 0 after NSLOT-1.
  - For a write, pulse wr_ok. rr is unchanged.
  - Return to IDLE.
- A slot that drops slot_req before it is granted is skipped, with no side effect. A slot still requesting after its slot_ok is re-arbitrated normally.
- Once a request is latched, changes on its slot_addr or wr_* inputs have no effect on the in-flight transaction.
- Ignored events:
  - sdram_ack outside WAIT_ACK.
  - data_rdy outside WAIT_RDY.
  - sdram_ack and data_rdy together in WAIT_ACK: only the ack is taken.
- downloading rising mid-transaction: the current transaction completes normally, then the FSM holds in IDLE.
- Simultaneous wr_req and slot_req in IDLE: the write wins and the read waits.

## Timing
- Reset values: state IDLE, sdram_req 0, sdram_rnw 1, sdram_addr/bank/wrmask/data_write 0, slot_ok 0, wr_ok 0, slot_dout 0, rr 0.
- Reset mid-transaction drops sdram_req on the next edge and no ok pulse is issued.
- Grant latency: request present in IDLE → sdram_req=1 one cycle later (registered).
- sdram_req falls on the cycle after sdram_ack is sampled.
- slot_ok/wr_ok rise one cycle after data_rdy is sampled and last exactly one cycle. slot_dout is valid from that cycle until the next read completes.
- Back-to-back: the earliest next sdram_req is two cycles after data_rdy (ok cycle, then IDLE grant).
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package jtframe_sdram_pkg holds:
  - the state enum (IDLE, WAIT_ACK, WAIT_RDY);
  - SDRAM_DW=32 and WR_DW=16 constants;
  - an owner-encoding constant OWNER_WR=NSLOT.
- Sub-module jtframe_rr_pick (NSLOT): combinational round-robin picker.
  - Inputs: request vector and rr.
  - Outputs: grant index and any flag.
  - Implemented as a rotate, priority encode, and un-rotate.

## Test plan
- Single read: slot 2 requests addr 0x12345, bank 1; the model acks after 3 cycles and gives data_rdy with 0xDEADBEEF after 5 more → sdram_addr=0x12345, rnw=1, slot_ok=0b0100 for one cycle, slot_dout=0xDEADBEEF.
- Round-robin: slots 0..3 all held requesting, 8 transactions → grant order 0,1,2,3,0,1,2,3, and each slot_ok fires twice.
- Write priority: wr_req with addr 0x100, data 0xA55A, mask 2'b01, raised together with slot 1 → the write is issued first with wrmask=01 and data_write=0xA55A, wr_ok pulses, then slot 1 is served.
- Download hold: downloading is raised while in WAIT_RDY of a slot 0 read → that read completes with slot_ok[0]; sdram_req stays 0 for 20 cycles while slot 3 requests; downloading falls → slot 3 is granted the next cycle.
- Reset mid-op: rst asserted in WAIT_ACK → next cycle sdram_req=0, no ok pulses, rr=0, and a stray data_rdy afterwards is ignored.
- Spurious handshakes: sdram_ack and data_rdy pulsed while IDLE with no requests → no outputs change.

Source files
------------

// File: rtl/jtframe_sdram_pkg.sv
// Shared types and constants for the SDRAM request arbiter.
package jtframe_sdram_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_RDY = 2'd2
    } arb_state_t;

    localparam int SDRAM_DW = 32;
    localparam int WR_DW    = 16;

    // Owner code wide enough for up to 8 read slots plus the write slot
    localparam int OWNER_W  = 4;

    // The write-back slot is encoded as owner NSLOT, one past the last read slot
    function automatic logic [OWNER_W-1:0] owner_wr(input int nslot);
        return OWNER_W'(nslot);
    endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so that slot rr
// sits at bit 0, priority-encode the lowest set bit, then rotate the index back.
module jtframe_rr_pick #(
    parameter int NSLOT = 4,
    parameter int RW    = $clog2(NSLOT)
) (
    input  logic [NSLOT-1:0] req,
    input  logic [RW-1:0]    rr,
    output logic [RW-1:0]    grant,
    output logic             any_req
);

    localparam logic [RW:0] NS = (RW+1)'(NSLOT);

    logic [2*NSLOT-1:0] dbl;
    logic [NSLOT-1:0]   rot;
    logic [RW-1:0]      off;
    logic               found;
    logic [RW:0]        sum;

    // Rotate, priority encode, un-rotate modulo NSLOT
    always_comb begin
        dbl   = {req, req};
        rot   = NSLOT'(dbl >> rr);
        off   = '0;
        found = 1'b0;
        for (int k = 0; k < NSLOT; k++) begin
            if (!found && rot[k]) begin
                off   = RW'(k);
                found = 1'b1;
            end
        end
        sum = {1'b0, rr} + {1'b0, off};
        if (sum >= NS) sum = sum - NS;
        grant   = sum[RW-1:0];
        any_req = |req;
    end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Shares the single SDRAM controller port between NSLOT read slots and one
// write-back slot. Writes win over reads, reads rotate round-robin, and no new
// grant is issued while a ROM download is running.
//
// Handshake: sdram_req is a level held with all sdram_* fields stable until
// sdram_ack is sampled high; data_rdy then closes the transaction and the
// owner receives a one-cycle slot_ok/wr_ok pulse on the following cycle.
module jtframe_sdram_arb
    import jtframe_sdram_pkg::*;
#(
    parameter int NSLOT = 4,
    parameter int AW    = 22
) (
    input  logic                    clk_rom,
    input  logic                    rst,
    input  logic                    downloading,
    input  logic [NSLOT-1:0]        slot_req,
    input  logic [NSLOT*AW-1:0]     slot_addr,
    input  logic [NSLOT*2-1:0]      slot_bank,
    output logic [NSLOT-1:0]        slot_ok,
    output logic [SDRAM_DW-1:0]     slot_dout,
    input  logic                    wr_req,
    input  logic [AW-1:0]           wr_addr,
    input  logic [1:0]              wr_bank,
    input  logic [WR_DW-1:0]        wr_data,
    input  logic [1:0]              wr_mask,
    output logic                    wr_ok,
    output logic                    sdram_req,
    input  logic                    sdram_ack,
    output logic [AW-1:0]           sdram_addr,
    output logic [1:0]              sdram_bank,
    output logic                    sdram_rnw,
    output logic [1:0]              sdram_wrmask,
    output logic [WR_DW-1:0]        data_write,
    input  logic [SDRAM_DW-1:0]     data_read,
    input  logic                    data_rdy,
    output arb_state_t              dbg_state,
    output logic [$clog2(NSLOT)-1:0] dbg_rr
);

    localparam int                 RW         = $clog2(NSLOT);
    localparam logic [OWNER_W-1:0] OWNER_WR   = owner_wr(NSLOT);
    localparam logic [OWNER_W-1:0] OWNER_LAST = OWNER_W'(NSLOT-1);

    arb_state_t         state_q, state_d;
    logic [OWNER_W-1:0] owner;
    logic [RW-1:0]      rr;
    logic [RW-1:0]      pick;
    logic               pick_any;
    logic               grant_wr, grant_rd, take_ack, done;

    jtframe_rr_pick #(.NSLOT(NSLOT)) u_pick (
        .req     (slot_req),
        .rr      (rr),
        .grant   (pick),
        .any_req (pick_any)
    );

    // State register
    always_ff @(posedge clk_rom) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: hold off grants while downloading, one transaction at a time
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!downloading && (wr_req || pick_any)) state_d = WAIT_ACK;
            WAIT_ACK: if (sdram_ack) state_d = WAIT_RDY;
            WAIT_RDY: if (data_rdy)  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Transition strobes that steer the registered datapath
    always_comb begin
        grant_wr = (state_q == IDLE) && !downloading && wr_req;
        grant_rd = (state_q == IDLE) && !downloading && !wr_req && pick_any;
        take_ack = (state_q == WAIT_ACK) && sdram_ack;
        done     = (state_q == WAIT_RDY) && data_rdy;
    end

    // Registered request fields, owner tracking, completion pulses and rr update
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            sdram_req    <= 1'b0;
            sdram_rnw    <= 1'b1;
            sdram_addr   <= '0;
            sdram_bank   <= '0;
            sdram_wrmask <= '0;
            data_write   <= '0;
            slot_ok      <= '0;
            wr_ok        <= 1'b0;
            slot_dout    <= '0;
            rr           <= '0;
            owner        <= '0;
        end else begin
            slot_ok <= '0;
            wr_ok   <= 1'b0;
            if (grant_wr) begin
                sdram_req    <= 1'b1;
                sdram_rnw    <= 1'b0;
                sdram_addr   <= wr_addr;
                sdram_bank   <= wr_bank;
                sdram_wrmask <= wr_mask;
                data_write   <= wr_data;
                owner        <= OWNER_WR;
            end else if (grant_rd) begin
                sdram_req    <= 1'b1;
                sdram_rnw    <= 1'b1;
                sdram_addr   <= slot_addr[pick*AW +: AW];
                sdram_bank   <= slot_bank[pick*2 +: 2];
                sdram_wrmask <= 2'b00;
                owner        <= OWNER_W'(pick);
            end
            if (take_ack) sdram_req <= 1'b0;
            if (done) begin
                if (owner == OWNER_WR) begin
                    wr_ok <= 1'b1;
                end else begin
                    slot_ok[owner[RW-1:0]] <= 1'b1;
                    slot_dout              <= data_read;
                    rr <= (owner == OWNER_LAST) ? '0 : owner[RW-1:0] + RW'(1);
                end
            end
        end
    end

    assign dbg_state = state_q;
    assign dbg_rr    = rr;

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Directed bench for jtframe_sdram_arb: a small SDRAM controller model answers
// requests, stimulus pushes expected requests/completions into queues, and a
// monitor pops and compares whenever the DUT issues a request or an ok pulse.
module tb_jtframe_sdram_arb;
    import jtframe_sdram_pkg::*;

    localparam int NSLOT = 4;
    localparam int AW    = 22;

    // ---------------- clock / reset ----------------
    logic clk_rom = 1'b0;
    always #5 clk_rom = ~clk_rom;

    logic                rst;
    logic                downloading;
    logic [NSLOT-1:0]    slot_req;
    logic [NSLOT*AW-1:0] slot_addr;
    logic [NSLOT*2-1:0]  slot_bank;
    logic [NSLOT-1:0]    slot_ok;
    logic [31:0]         slot_dout;
    logic                wr_req;
    logic [AW-1:0]       wr_addr;
    logic [1:0]          wr_bank;
    logic [15:0]         wr_data;
    logic [1:0]          wr_mask;
    logic                wr_ok;
    logic                sdram_req;
    logic                sdram_ack;
    logic [AW-1:0]       sdram_addr;
    logic [1:0]          sdram_bank;
    logic                sdram_rnw;
    logic [1:0]          sdram_wrmask;
    logic [15:0]         data_write;
    logic [31:0]         data_read;
    logic                data_rdy;
    arb_state_t          dbg_state;
    logic [1:0]          dbg_rr;

    logic m_ack, m_rdy, t_ack, t_rdy;
    assign sdram_ack = m_ack | t_ack;
    assign data_rdy  = m_rdy | t_rdy;

    jtframe_sdram_arb #(.NSLOT(NSLOT), .AW(AW)) dut (
        .clk_rom(clk_rom), .rst(rst), .downloading(downloading),
        .slot_req(slot_req), .slot_addr(slot_addr), .slot_bank(slot_bank),
        .slot_ok(slot_ok), .slot_dout(slot_dout),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .wr_data(wr_data), .wr_mask(wr_mask), .wr_ok(wr_ok),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
        .sdram_bank(sdram_bank), .sdram_rnw(sdram_rnw), .sdram_wrmask(sdram_wrmask),
        .data_write(data_write), .data_read(data_read), .data_rdy(data_rdy),
        .dbg_state(dbg_state), .dbg_rr(dbg_rr)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [42:0] req_q[$];   // {rnw, bank, addr, mask, data}
    logic [35:0] ok_q[$];    // {is_wr, slot, dout}
    logic [31:0] data_q[$];  // read data the model returns, in order
    int ack_dly = 1;
    int rdy_dly = 1;
    int rem[NSLOT];
    int rem_wr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event at %0t", name, $time);
    endtask

    function automatic logic [42:0] req_pack(input logic rnw, input logic [1:0] bank,
                                             input logic [AW-1:0] addr, input logic [1:0] mask,
                                             input logic [15:0] data);
        return {rnw, bank, addr, mask, data};
    endfunction

    // ---------------- SDRAM controller model ----------------
    int m_st, m_cnt;
    initial begin
        m_ack = 1'b0; m_rdy = 1'b0; data_read = '0; m_st = 0; m_cnt = 0;
        forever begin
            @(negedge clk_rom);
            if (rst) begin
                m_st = 0; m_ack = 1'b0; m_rdy = 1'b0;
            end else begin
                case (m_st)
                    0: begin
                        m_rdy = 1'b0;
                        if (sdram_req) begin m_cnt = ack_dly; m_st = 1; end
                    end
                    1: begin
                        m_cnt--;
                        if (m_cnt <= 0) begin m_ack = 1'b1; m_cnt = rdy_dly; m_st = 2; end
                    end
                    2: begin
                        m_ack = 1'b0;
                        m_cnt--;
                        if (m_cnt <= 0) begin
                            m_rdy = 1'b1;
                            data_read = (sdram_rnw && data_q.size() > 0) ? data_q.pop_front() : 32'h0;
                            m_st = 3;
                        end
                    end
                    default: begin m_rdy = 1'b0; m_st = 0; end
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic        req_prev;
        logic [42:0] hold, act_req;
        logic [35:0] act_ok;
        int          idx;
        req_prev = 1'b0;
        hold = '0;
        forever begin
            @(negedge clk_rom);
            if (rst) begin
                req_prev = 1'b0;
            end else begin
                act_req = req_pack(sdram_rnw, sdram_bank, sdram_addr,
                                   sdram_rnw ? 2'b00 : sdram_wrmask,
                                   sdram_rnw ? 16'h0 : data_write);
                if (sdram_req && !req_prev) begin
                    if (req_q.size() == 0) chk("unexpected_req", 1, 0);
                    else chk("req_fields", act_req, req_q.pop_front());
                    hold = act_req;
                end else if (sdram_req && req_prev) begin
                    chk("req_hold", act_req, hold);
                end
                if (slot_ok != '0 || wr_ok) begin
                    chk("ok_onehot", $countones({wr_ok, slot_ok}), 1);
                    idx = 0;
                    for (int i = 0; i < NSLOT; i++) if (slot_ok[i]) idx = i;
                    act_ok = wr_ok ? {1'b1, 3'd0, 32'd0} : {1'b0, 3'(idx), slot_dout};
                    if (ok_q.size() == 0) chk("unexpected_ok", 1, 0);
                    else chk("ok_pulse", act_ok, ok_q.pop_front());
                end
                req_prev = sdram_req;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_slot(input int s, input logic [AW-1:0] a, input logic [1:0] b);
        slot_addr[s*AW +: AW] = a;
        slot_bank[s*2 +: 2]   = b;
    endtask

    task automatic expect_read(input int s, input logic [AW-1:0] a, input logic [1:0] b,
                               input logic [31:0] d);
        req_q.push_back(req_pack(1'b1, b, a, 2'b00, 16'h0));
        ok_q.push_back({1'b0, 3'(s), d});
        data_q.push_back(d);
    endtask

    // Wait for all outstanding ok pulses; each client drops its request on its last ok
    task automatic wait_oks();
        int guard = 0;
        int left;
        left = rem_wr;
        for (int i = 0; i < NSLOT; i++) left += rem[i];
        while (left > 0 && guard < 3000) begin
            @(negedge clk_rom);
            guard++;
            if (wr_ok && rem_wr > 0) begin
                rem_wr--;
                if (rem_wr == 0) wr_req = 1'b0;
            end
            for (int i = 0; i < NSLOT; i++) begin
                if (slot_ok[i] && rem[i] > 0) begin
                    rem[i]--;
                    if (rem[i] == 0) slot_req[i] = 1'b0;
                end
            end
            left = rem_wr;
            for (int i = 0; i < NSLOT; i++) left += rem[i];
        end
        if (left > 0) fail_now("wait_oks");
    endtask

    task automatic check_quiet(input string tag, input logic [31:0] dout_exp);
        chk({tag, "_req"}, sdram_req, 1'b0);
        chk({tag, "_ok"}, {wr_ok, slot_ok}, 5'b0);
        chk({tag, "_dout"}, slot_dout, dout_exp);
        chk({tag, "_state"}, dbg_state, IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        rst = 1'b1; downloading = 1'b0; slot_req = '0; slot_addr = '0; slot_bank = '0;
        wr_req = 1'b0; wr_addr = '0; wr_bank = '0; wr_data = '0; wr_mask = '0;
        t_ack = 1'b0; t_rdy = 1'b0;
        for (int i = 0; i < NSLOT; i++) rem[i] = 0;
        rem_wr = 0;
        repeat (3) @(negedge clk_rom);

        // Reset values
        chk("rst_req", sdram_req, 1'b0);
        chk("rst_rnw", sdram_rnw, 1'b1);
        chk("rst_addr", sdram_addr, 22'h0);
        chk("rst_bank_mask", {sdram_bank, sdram_wrmask}, 4'h0);
        chk("rst_data_write", data_write, 16'h0);
        chk("rst_ok", {wr_ok, slot_ok}, 5'b0);
        chk("rst_dout", slot_dout, 32'h0);
        chk("rst_rr", dbg_rr, 2'd0);
        chk("rst_state", dbg_state, IDLE);
        rst = 1'b0;

        // Round-robin: all four slots held, two rounds in order 0,1,2,3
        ack_dly = 1; rdy_dly = 1;
        for (int s = 0; s < NSLOT; s++) set_slot(s, AW'(32'h1000 * (s + 1) + 32'h11), 2'(s));
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < NSLOT; s++)
                expect_read(s, AW'(32'h1000 * (s + 1) + 32'h11), 2'(s), 32'hC0DE0000 + 32'(k * 16 + s));
        for (int s = 0; s < NSLOT; s++) rem[s] = 2;
        slot_req = 4'b1111;
        wait_oks();
        chk("rr_after_rounds", dbg_rr, 2'd0);

        // Single read from slot 2
        ack_dly = 3; rdy_dly = 5;
        set_slot(2, 22'h12345, 2'd1);
        expect_read(2, 22'h12345, 2'd1, 32'hDEADBEEF);
        rem[2] = 1;
        slot_req[2] = 1'b1;
        wait_oks();
        repeat (3) @(negedge clk_rom);
        chk("dout_held", slot_dout, 32'hDEADBEEF);
        chk("rr_after_slot2", dbg_rr, 2'd3);

        // Reset while waiting for the ack
        ack_dly = 30; rdy_dly = 2;
        set_slot(1, 22'h00777, 2'd0);
        req_q.push_back(req_pack(1'b1, 2'd0, 22'h00777, 2'b00, 16'h0));
        slot_req[1] = 1'b1;
        guard = 0;
        while (!sdram_req && guard < 50) begin @(negedge clk_rom); guard++; end
        if (!sdram_req) fail_now("reset_test_req");
        slot_req = '0;
        rst = 1'b1;
        @(negedge clk_rom);
        chk("midrst_req", sdram_req, 1'b0);
        chk("midrst_state", dbg_state, IDLE);
        chk("midrst_rr", dbg_rr, 2'd0);
        chk("midrst_ok", {wr_ok, slot_ok}, 5'b0);
        @(negedge clk_rom);
        rst = 1'b0;
        t_rdy = 1'b1;
        @(negedge clk_rom);
        t_rdy = 1'b0;
        repeat (3) begin
            @(negedge clk_rom);
            check_quiet("stray_rdy", 32'h0);
        end

        // Spurious handshakes while idle
        t_ack = 1'b1; t_rdy = 1'b1;
        @(negedge clk_rom);
        t_ack = 1'b0; t_rdy = 1'b0;
        repeat (3) begin
            @(negedge clk_rom);
            check_quiet("spurious", 32'h0);
            chk("spurious_fields", {sdram_rnw, sdram_addr, data_write}, {1'b1, 22'h0, 16'h0});
        end

        // Write priority over a simultaneous slot 1 read
        ack_dly = 2; rdy_dly = 3;
        wr_addr = 22'h100; wr_bank = 2'd2; wr_data = 16'hA55A; wr_mask = 2'b01;
        set_slot(1, 22'h02222, 2'd3);
        req_q.push_back(req_pack(1'b0, 2'd2, 22'h100, 2'b01, 16'hA55A));
        ok_q.push_back({1'b1, 3'd0, 32'd0});
        expect_read(1, 22'h02222, 2'd3, 32'h5A5A1234);
        rem_wr = 1; rem[1] = 1;
        wr_req = 1'b1; slot_req[1] = 1'b1;
        @(negedge clk_rom);
        wr_addr = 22'h3FFFF; wr_data = 16'hFFFF; wr_mask = 2'b10;
        wait_oks();
        chk("rr_after_write", dbg_rr, 2'd2);

        // Download hold: raised in WAIT_RDY of a slot 0 read
        ack_dly = 2; rdy_dly = 6;
        set_slot(0, 22'h0ABCD, 2'd0);
        expect_read(0, 22'h0ABCD, 2'd0, 32'h0D0D0D0D);
        rem[0] = 1;
        slot_req[0] = 1'b1;
        guard = 0;
        while (dbg_state != WAIT_RDY && guard < 50) begin @(negedge clk_rom); guard++; end
        if (dbg_state != WAIT_RDY) fail_now("dl_wait_rdy");
        downloading = 1'b1;
        wait_oks();
        set_slot(3, 22'h3F00F, 2'd2);
        expect_read(3, 22'h3F00F, 2'd2, 32'h33334444);
        slot_req[3] = 1'b1;
        repeat (20) begin
            @(negedge clk_rom);
            chk("dl_hold_req", sdram_req, 1'b0);
        end
        downloading = 1'b0;
        @(negedge clk_rom);
        chk("dl_release_req", sdram_req, 1'b1);
        rem[3] = 1;
        wait_oks();
        chk("rr_after_dl", dbg_rr, 2'd0);

        repeat (4) @(negedge clk_rom);
        chk("req_q_drained", req_q.size(), 0);
        chk("ok_q_drained", ok_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
